// File: rtl/button_pkg.sv
// Shared types and helpers for the pushbutton event processor.
// Holds the per-channel press FSM encoding and the counter-width helper.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } press_state_e;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 32'd1 : unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: 2-FF synchroniser, debouncer and press classifier
// producing single-cycle short/long/repeat pulses plus the debounced level.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 2000,
    parameter int unsigned REPEAT_MS   = 250,
    parameter bit          REPEAT_EN   = 1'b0
) (
    input  logic clk_1khz,
    input  logic rst_ni,
    input  logic pushbutton_i,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_MS + 1);
    localparam int unsigned HW = cnt_width(LONG_MS);
    localparam int unsigned RW = cnt_width(REPEAT_MS + 1);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_MS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_MS - 1);

    logic [1:0]    sync_q;
    logic          db_q;
    logic [DW-1:0] dcnt_q;
    logic          db_toggle;
    logic          db_rise;
    press_state_e  state_q;
    logic [HW-1:0] hcnt_q;
    logic [RW-1:0] rcnt_q;

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pushbutton_i};
        end
    end

    assign db_toggle = (sync_q[1] != db_q) && (dcnt_q == D_LAST);
    assign db_rise   = db_toggle && !db_q;

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            db_q   <= 1'b0;
            dcnt_q <= '0;
        end else if (sync_q[1] == db_q) begin
            dcnt_q <= '0;
        end else if (db_toggle) begin
            db_q   <= ~db_q;
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_q + 1'b1;
        end
    end

    // The press starts on the debouncer's toggle edge so that hold time is
    // counted from the db rise; a fall is seen one cycle later on db_q.
    // With a one-cycle debounce a new rise can coincide with that fall, so
    // the fall branches re-enter PRESS directly instead of missing it.
    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            rcnt_q   <= '0;
            short_o  <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
        end else begin
            short_o  <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (db_rise) begin
                        state_q <= PRESS;
                        hcnt_q  <= '0;
                    end
                end
                PRESS: begin
                    if (!db_q) begin
                        short_o <= 1'b1;
                        state_q <= db_rise ? PRESS : IDLE;
                        hcnt_q  <= '0;
                    end else if (hcnt_q == H_LAST) begin
                        long_o  <= 1'b1;
                        state_q <= LONG;
                        rcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end
                LONG: begin
                    if (!db_q) begin
                        state_q <= db_rise ? PRESS : IDLE;
                        hcnt_q  <= '0;
                    end else if (REPEAT_EN) begin
                        if (rcnt_q == R_LAST) begin
                            repeat_o <= 1'b1;
                            rcnt_q   <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign held_o = db_q;

endmodule

// File: rtl/button_event_processor.sv
// Multi-channel pushbutton event processor: N_CH independent button_channel
// instances feeding the scoreboard counters with short/long/repeat pulses.
module button_event_processor #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 2000,
    parameter int unsigned REPEAT_MS   = 250,
    parameter bit          REPEAT_EN   = 1'b0
) (
    input  logic            clk_1khz,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] pushbutton_i,
    output logic [N_CH-1:0] short_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] repeat_o,
    output logic [N_CH-1:0] held_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS),
            .REPEAT_MS  (REPEAT_MS),
            .REPEAT_EN  (REPEAT_EN)
        ) u_ch (
            .clk_1khz    (clk_1khz),
            .rst_ni      (rst_ni),
            .pushbutton_i(pushbutton_i[i]),
            .short_o     (short_o[i]),
            .long_o      (long_o[i]),
            .repeat_o    (repeat_o[i]),
            .held_o      (held_o[i])
        );
    end

endmodule
